// File: rtl/axicb_slv_rd_sched.sv
`default_nettype none
// ============================================================================
// Module      : axicb_slv_rd_sched
// Description : Slave-port read scheduler. Round-robin AR arbitration across
//               master switches, grant-order FIFO, and R burst steering.
// Revision    : 1.0 - initial release
// ============================================================================
module axicb_slv_rd_sched #(
  parameter int MST_NB   = 4,
  parameter int ARCH_W   = 8,
  parameter int RCH_W    = 8,
  parameter int OSTD_NUM = 4
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        srst,
  input  logic [MST_NB-1:0]           i_arvalid,
  output logic [MST_NB-1:0]           i_arready,
  input  logic [MST_NB*ARCH_W-1:0]    i_arch,
  output logic [MST_NB-1:0]           i_rvalid,
  input  logic [MST_NB-1:0]           i_rready,
  output logic [MST_NB-1:0]           i_rlast,
  output logic [RCH_W-1:0]            i_rch,
  output logic                        o_arvalid,
  input  logic                        o_arready,
  output logic [ARCH_W-1:0]           o_arch,
  input  logic                        o_rvalid,
  output logic                        o_rready,
  input  logic                        o_rlast,
  input  logic [RCH_W-1:0]            o_rch,
  output logic [$clog2(OSTD_NUM):0]   ostd_cnt
);

  localparam int c_mst_w = $clog2(MST_NB);
  localparam int c_cnt_w = $clog2(OSTD_NUM) + 1;
  localparam int c_ptr_w = (OSTD_NUM > 1) ? $clog2(OSTD_NUM) : 1;

  logic [c_mst_w-1:0] r_rr_ptr;
  logic [c_mst_w-1:0] r_lock_gnt;
  logic               r_lock;
  logic [c_cnt_w-1:0] r_ostd_cnt;
  logic [c_mst_w-1:0] w_rr_gnt;
  logic [c_mst_w-1:0] w_gnt;
  logic [c_mst_w-1:0] w_rr_nxt;
  logic [c_mst_w-1:0] w_head;
  logic               w_full;
  logic               w_empty;
  logic               w_any_req;
  logic               w_push;
  logic               w_pop;

  assign w_full    = (r_ostd_cnt == c_cnt_w'(OSTD_NUM));
  assign w_empty   = (r_ostd_cnt == '0);
  assign w_any_req = |i_arvalid;

  // Walk the search order backwards so the first requester after the pointer wins.
  always_comb begin
    w_rr_gnt = r_rr_ptr;
    for (int i = MST_NB - 1; i >= 0; i--) begin
      if (i_arvalid[(int'(r_rr_ptr) + i) % MST_NB])
        w_rr_gnt = c_mst_w'((int'(r_rr_ptr) + i) % MST_NB);
    end
  end

  assign w_gnt    = r_lock ? r_lock_gnt : w_rr_gnt;
  assign w_rr_nxt = (w_gnt == c_mst_w'(MST_NB - 1)) ? '0 : w_gnt + 1'b1;

  assign o_arvalid = w_any_req & ~w_full;
  assign o_arch    = i_arch[w_gnt*ARCH_W +: ARCH_W];
  assign w_push    = o_arvalid & o_arready;

  always_comb begin
    i_arready        = '0;
    i_arready[w_gnt] = o_arready & ~w_full;
  end

  always_comb begin
    i_rvalid = '0;
    i_rlast  = '0;
    if (!w_empty) begin
      i_rvalid[w_head] = o_rvalid;
      i_rlast[w_head]  = o_rlast;
    end
  end

  assign o_rready = ~w_empty & i_rready[w_head];
  assign i_rch    = o_rch;
  assign w_pop    = o_rvalid & o_rready & o_rlast;
  assign ostd_cnt = r_ostd_cnt;

  // A pending request that did not issue (slave stall or full) freezes the grant.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rr_ptr   <= '0;
      r_lock     <= 1'b0;
      r_lock_gnt <= '0;
      r_ostd_cnt <= '0;
    end else if (srst) begin
      r_rr_ptr   <= '0;
      r_lock     <= 1'b0;
      r_lock_gnt <= '0;
      r_ostd_cnt <= '0;
    end else begin
      if (w_push) begin
        r_rr_ptr <= w_rr_nxt;
        r_lock   <= 1'b0;
      end else if (w_any_req && !r_lock) begin
        r_lock     <= 1'b1;
        r_lock_gnt <= w_gnt;
      end
      r_ostd_cnt <= r_ostd_cnt + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
    end
  end

  generate
    if (OSTD_NUM > 1) begin : g_fifo_multi
      logic [c_mst_w-1:0] r_mem [OSTD_NUM];
      logic [c_ptr_w-1:0] r_wptr;
      logic [c_ptr_w-1:0] r_rptr;

      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          r_wptr <= '0;
          r_rptr <= '0;
        end else if (srst) begin
          r_wptr <= '0;
          r_rptr <= '0;
        end else begin
          if (w_push) r_wptr <= r_wptr + 1'b1;
          if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
      end

      always_ff @(posedge aclk) begin
        if (w_push) r_mem[r_wptr] <= w_gnt;
      end

      assign w_head = r_mem[r_rptr];
    end else begin : g_fifo_single
      logic [c_mst_w-1:0] r_slot;

      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)    r_slot <= '0;
        else if (srst)   r_slot <= '0;
        else if (w_push) r_slot <= w_gnt;
      end

      assign w_head = r_slot;
    end
  endgenerate

`ifndef SYNTHESIS
  a_no_push_full: assert property (@(posedge aclk) disable iff (!aresetn || srst)
    !(w_push && w_full));
  a_no_pop_empty: assert property (@(posedge aclk) disable iff (!aresetn || srst)
    !(w_pop && w_empty));
  a_arch_stable: assert property (@(posedge aclk) disable iff (!aresetn || srst)
    (o_arvalid && !o_arready) |=> $stable(o_arch));
`endif

endmodule
`default_nettype wire

// File: tb/tb_axicb_slv_rd_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_axicb_slv_rd_sched
// Description : Self-checking bench for axicb_slv_rd_sched (4 masters, 4 ostd).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axicb_slv_rd_sched;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        srst;
  logic [3:0]  i_arvalid;
  logic [3:0]  i_arready;
  logic [31:0] i_arch;
  logic [3:0]  i_rvalid;
  logic [3:0]  i_rready;
  logic [3:0]  i_rlast;
  logic [7:0]  i_rch;
  logic        o_arvalid;
  logic        o_arready;
  logic [7:0]  o_arch;
  logic        o_rvalid;
  logic        o_rready;
  logic        o_rlast;
  logic [7:0]  o_rch;
  logic [2:0]  ostd_cnt;

  axicb_slv_rd_sched #(
    .MST_NB(4), .ARCH_W(8), .RCH_W(8), .OSTD_NUM(4)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .i_arvalid(i_arvalid), .i_arready(i_arready), .i_arch(i_arch),
    .i_rvalid(i_rvalid), .i_rready(i_rready), .i_rlast(i_rlast), .i_rch(i_rch),
    .o_arvalid(o_arvalid), .o_arready(o_arready), .o_arch(o_arch),
    .o_rvalid(o_rvalid), .o_rready(o_rready), .o_rlast(o_rlast), .o_rch(o_rch),
    .ostd_cnt(ostd_cnt)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [3:0] arv;
    logic       ardy;
    logic       rv;
    logic       rl;
    logic [3:0] exp_iardy;
    logic       exp_oarv;
    logic [7:0] exp_arch;
    logic [3:0] exp_irv;
    logic       exp_ordy;
    int         exp_cnt;
  } vec_t;

  typedef struct {
    int         m;
    logic       last;
    logic [7:0] data;
  } beat_t;

  int    n_chk = 0;
  int    n_fail = 0;
  int    exp_cnt = 0;
  int    beat_id = 0;
  beat_t sb[$];
  int    slv_len[$];
  vec_t  tbl[12];
  logic [31:0] lmask;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic push_burst(input int m, input int len);
    for (int b = 0; b < len; b++) begin
      sb.push_back('{m, (b == len - 1), 8'(beat_id)});
      beat_id++;
    end
    slv_len.push_back(len);
    exp_cnt++;
  endtask

  task automatic ar_issue(input logic [3:0] mask, input int m, input int blen);
    i_arvalid = mask;
    o_arready = 1'b1;
    #4;
    chk("ar_valid", 32'(o_arvalid), 32'd1);
    chk("ar_payload", 32'(o_arch), 32'hA0 + m);
    chk("ar_ready", 32'(i_arready), 32'(4'(1) << m));
    chk("ar_cnt", 32'(ostd_cnt), 32'(exp_cnt));
    push_burst(m, blen);
    tick();
    i_arvalid = '0;
    o_arready = 1'b0;
  endtask

  // Slave side: play back expected beats, optionally stalling the head master.
  task automatic run_r(input int nbeats, input int stall_at, input int stall_len,
                       output logic [31:0] lastmask);
    int sent = 0;
    int cyc = 0;
    int stalled = 0;
    int pos = 0;
    lastmask = '0;
    while (sent < nbeats && cyc < 100) begin
      beat_t e;
      logic  stall;
      if (sb.size() == 0) begin
        chk("r_scoreboard_empty", 32'(sent), 32'(nbeats));
        break;
      end
      e = sb[0];
      stall = (sent == stall_at) && (stalled < stall_len);
      o_rvalid = 1'b1;
      o_rch    = e.data;
      o_rlast  = (pos == slv_len[0] - 1);
      i_rready = stall ? ~(4'(1) << e.m) : 4'hF;
      #4;
      chk("r_valid", 32'(i_rvalid), 32'(4'(1) << e.m));
      chk("r_last", 32'(i_rlast), e.last ? 32'(4'(1) << e.m) : 32'd0);
      chk("r_ready", 32'(o_rready), 32'(!stall));
      chk("r_data", 32'(i_rch), 32'(e.data));
      chk("r_cnt", 32'(ostd_cnt), 32'(exp_cnt));
      tick();
      if (stall) begin
        stalled++;
      end else begin
        if (e.last) begin
          lastmask[sent] = 1'b1;
          exp_cnt--;
          void'(slv_len.pop_front());
          pos = 0;
        end else begin
          pos++;
        end
        void'(sb.pop_front());
        sent++;
      end
      cyc++;
    end
    o_rvalid = 1'b0;
    o_rlast  = 1'b0;
    i_rready = '0;
    chk("r_budget", 32'(sent), 32'(nbeats));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // arv ardy rv rl | iardy oarv arch irv ordy cnt
    tbl[0]  = '{4'b0101, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b1, 8'hA0, 4'b0000, 1'b0, 0};
    tbl[1]  = '{4'b0101, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b1, 8'hA2, 4'b0000, 1'b1, 1};
    tbl[2]  = '{4'b0101, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b1, 8'hA0, 4'b0000, 1'b1, 2};
    tbl[3]  = '{4'b0101, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b1, 8'hA2, 4'b0000, 1'b1, 3};
    tbl[4]  = '{4'b0101, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b1, 4};
    tbl[5]  = '{4'b0101, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0001, 1'b1, 4};
    tbl[6]  = '{4'b0101, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b1, 8'hA0, 4'b0000, 1'b1, 3};
    tbl[7]  = '{4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0100, 1'b1, 4};
    tbl[8]  = '{4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0001, 1'b1, 3};
    tbl[9]  = '{4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0100, 1'b1, 2};
    tbl[10] = '{4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0001, 1'b1, 1};
    tbl[11] = '{4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 0};

    aresetn   = 1'b0;
    srst      = 1'b0;
    i_arvalid = '0;
    i_arch    = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    i_rready  = '0;
    o_arready = 1'b0;
    o_rvalid  = 1'b0;
    o_rlast   = 1'b0;
    o_rch     = 8'h5A;

    repeat (2) @(posedge aclk);
    #2;
    chk("rst_arvalid", 32'(o_arvalid), 32'd0);
    chk("rst_iarready", 32'(i_arready), 32'd0);
    chk("rst_irvalid", 32'(i_rvalid), 32'd0);
    chk("rst_orready", 32'(o_rready), 32'd0);
    chk("rst_cnt", 32'(ostd_cnt), 32'd0);
    chk("rst_rch", 32'(i_rch), 32'h5A);
    @(negedge aclk);
    aresetn = 1'b1;
    tick();

    // Alternating grants, fill to full, single-beat release, then drain.
    foreach (tbl[k]) begin
      i_arvalid = tbl[k].arv;
      o_arready = tbl[k].ardy;
      o_rvalid  = tbl[k].rv;
      o_rlast   = tbl[k].rl;
      i_rready  = 4'hF;
      #4;
      chk("tbl_iarready", 32'(i_arready), 32'(tbl[k].exp_iardy));
      chk("tbl_oarvalid", 32'(o_arvalid), 32'(tbl[k].exp_oarv));
      if (tbl[k].exp_oarv) chk("tbl_arch", 32'(o_arch), 32'(tbl[k].exp_arch));
      chk("tbl_irvalid", 32'(i_rvalid), 32'(tbl[k].exp_irv));
      chk("tbl_irlast", 32'(i_rlast), tbl[k].rl ? 32'(tbl[k].exp_irv) : 32'd0);
      chk("tbl_orready", 32'(o_rready), 32'(tbl[k].exp_ordy));
      chk("tbl_cnt", 32'(ostd_cnt), 32'(tbl[k].exp_cnt));
      tick();
    end
    i_arvalid = '0;
    o_arready = 1'b0;
    o_rvalid  = 1'b0;
    o_rlast   = 1'b0;
    i_rready  = '0;
    exp_cnt   = 0;

    // Move pointer to 0, then a stalled master 1 must hold its grant against master 0.
    ar_issue(4'b1000, 3, 1);
    i_arvalid = 4'b0010;
    #4;
    chk("lock_valid", 32'(o_arvalid), 32'd1);
    chk("lock_arch_c1", 32'(o_arch), 32'hA1);
    tick();
    i_arvalid = 4'b0011;
    for (int c = 0; c < 2; c++) begin
      #4;
      chk("lock_arch_c2", 32'(o_arch), 32'hA1);
      chk("lock_iarready", 32'(i_arready), 32'd0);
      tick();
    end
    o_arready = 1'b1;
    #4;
    chk("lock_accept_m1", 32'(o_arch), 32'hA1);
    chk("lock_ready_m1", 32'(i_arready), 32'b0010);
    push_burst(1, 1);
    tick();
    ar_issue(4'b0001, 0, 1);
    run_r(3, -1, 0, lmask);
    chk("lock_rlast_beats", lmask, 32'h7);

    // Grants 3,0,1 with bursts 4/1/2; head master stalls mid-burst for 5 cycles.
    ar_issue(4'b1000, 3, 4);
    ar_issue(4'b0001, 0, 1);
    ar_issue(4'b0010, 1, 2);
    run_r(7, 1, 5, lmask);
    chk("burst_rlast_beats", lmask, 32'h58);

    // Synchronous reset with two outstanding and a locked grant.
    ar_issue(4'b1000, 3, 1);
    ar_issue(4'b0001, 0, 1);
    i_arvalid = 4'b0100;
    o_arready = 1'b0;
    #4;
    chk("srst_pre_arch", 32'(o_arch), 32'hA2);
    chk("srst_pre_cnt", 32'(ostd_cnt), 32'd2);
    tick();
    i_arvalid = '0;
    srst = 1'b1;
    tick();
    srst = 1'b0;
    sb.delete();
    slv_len.delete();
    exp_cnt   = 0;
    i_arvalid = 4'b1001;
    o_rvalid  = 1'b1;
    i_rready  = 4'hF;
    #4;
    chk("srst_cnt", 32'(ostd_cnt), 32'd0);
    chk("srst_arch_rr0", 32'(o_arch), 32'hA0);
    chk("srst_iarready", 32'(i_arready), 32'd0);
    chk("srst_irvalid", 32'(i_rvalid), 32'd0);
    chk("srst_orready", 32'(o_rready), 32'd0);
    tick();
    i_arvalid = '0;
    o_rvalid  = 1'b0;
    i_rready  = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
